// File: rtl/secded_decode_engine_if.sv
// secded_decode_engine_if: request/status and data-memory port bundle for the SECDED decode engine.
interface secded_decode_engine_if #(parameter int AW = 8);
  logic          req;
  logic          done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    n_single;
  logic [7:0]    n_double;
  modport master (output req, mem_rdata,
                  input  done, busy, mem_addr, mem_we, mem_wdata, n_single, n_double);
  modport slave  (input  req, mem_rdata,
                  output done, busy, mem_addr, mem_we, mem_wdata, n_single, n_double);
endinterface

// File: rtl/secded_decode_engine.sv
// secded_decode_engine: walks NUM_WORDS Hamming(16,11) words in memory, corrects/flags them, writes results back.
module secded_decode_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input logic                  clk,
  input logic                  reset,
  secded_decode_engine_if.slave bus
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [3:0] DPOS [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_e;
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   w_q, w_d;
  logic [7:0]    ns_q, ns_d, nd_q, nd_d;
  logic          done_q, done_d;
  logic [3:0]    syn;
  logic          par, dbl;
  logic [10:0]   d;
  logic [15:0]   dec;
  logic [AW-1:0] src_a, dst_a, addr;
  logic          we;
  logic [7:0]    wdata;
  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) syn = syn ^ (w_q[k] ? 4'(k) : 4'd0);
    par = ^w_q;
    dbl = !par && syn != 4'd0;
    d = '0;
    for (int k = 0; k < 11; k++) d[k] = w_q[DPOS[k]] ^ (par && syn == DPOS[k]);
    dec = {par ? 5'b01000 : dbl ? 5'b10000 : 5'b00000, d};
  end
  assign src_a = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
  assign dst_a = AW'(DST_BASE) + AW'({idx_q, 1'b0});
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    ns_d    = ns_q;
    nd_d    = nd_q;
    done_d  = done_q;
    addr    = '0;
    we      = 1'b0;
    wdata   = '0;
    case (state_q)
      IDLE, DONE: if (bus.req) begin
        state_d = RD_LO;
        idx_d   = '0;
        ns_d    = '0;
        nd_d    = '0;
        done_d  = 1'b0;
      end
      RD_LO: begin
        addr       = src_a;
        w_d[7:0]   = bus.mem_rdata;
        state_d    = RD_HI;
      end
      RD_HI: begin
        addr       = src_a + AW'(1);
        w_d[15:8]  = bus.mem_rdata;
        state_d    = WR_LO;
      end
      WR_LO: begin
        addr    = dst_a;
        we      = 1'b1;
        wdata   = dec[7:0];
        ns_d    = (par && ns_q != 8'hFF) ? ns_q + 8'd1 : ns_q;
        nd_d    = (dbl && nd_q != 8'hFF) ? nd_q + 8'd1 : nd_q;
        state_d = WR_HI;
      end
      WR_HI: begin
        addr    = dst_a + AW'(1);
        we      = 1'b1;
        wdata   = dec[15:8];
        state_d = (idx_q == IW'(NUM_WORDS - 1)) ? DONE : RD_LO;
        done_d  = (idx_q == IW'(NUM_WORDS - 1));
        idx_d   = (idx_q == IW'(NUM_WORDS - 1)) ? idx_q : idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      w_q     <= '0;
      ns_q    <= '0;
      nd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      ns_q    <= ns_d;
      nd_q    <= nd_d;
      done_q  <= done_d;
    end
  end
  assign bus.done      = done_q;
  assign bus.busy      = !(state_q inside {IDLE, DONE});
  assign bus.mem_addr  = addr;
  assign bus.mem_we    = we;
  assign bus.mem_wdata = wdata;
  assign bus.n_single  = ns_q;
  assign bus.n_double  = nd_q;
endmodule

// File: tb/tb_secded_decode_engine.sv
// tb_secded_decode_engine: scoreboard bench; stimulus queues expected writes, a monitor checks every memory write.
module tb_secded_decode_engine;
  localparam int NW = 15, SRC = 30, DST = 0;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  secded_decode_engine_if #(.AW(8)) bus();
  secded_decode_engine #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  // Hand-computed vectors: encoded word, expected 16-bit result
  logic [15:0] tw [NW] = '{16'h000F, 16'h0007, 16'h000E, 16'h0207, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFE,
                           16'h7FFF, 16'h3FFF, 16'h0010, 16'h0018, 16'h8117, 16'h8157, 16'h0137};
  logic [15:0] te [NW] = '{16'h0001, 16'h4001, 16'h4001, 16'h8010, 16'h0000, 16'h4000, 16'h07FF, 16'h47FF,
                           16'h47FF, 16'h81FF, 16'h4000, 16'h8001, 16'h0400, 16'h4400, 16'h8002};
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [15:0] w);
    logic [3:0] s;
    int ones;
    logic [15:0] c;
    logic [4:0] f;
    s = 0; ones = 0; c = w; f = 5'b00000;
    for (int k = 0; k < 16; k++) if (w[k]) begin ones++; s = s ^ 4'(k); end
    if (ones % 2 == 1) begin c[s] = ~c[s]; f = 5'b01000; end
    else if (s != 0) f = 5'b10000;
    return {f, c[15:9], c[7:5], c[3]};
  endfunction
  function automatic logic [15:0] encode(input logic [10:0] dd);
    logic [15:0] w;
    logic [3:0] s;
    w = '0; s = 0;
    w[3] = dd[0]; w[7:5] = dd[3:1]; w[15:9] = dd[10:4];
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
    w[1] = s[0]; w[2] = s[1]; w[4] = s[2]; w[8] = s[3];
    w[0] = ^w;
    return w;
  endfunction
  initial forever begin
    @(negedge clk);
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(bus.mem_addr), int'(e[15:8]));
        chk("wr_data", int'(bus.mem_wdata), int'(e[7:0]));
      end
    end
  end
  task automatic load(input logic [15:0] ws [NW], output int es, output int ed);
    logic [15:0] r;
    es = 0; ed = 0;
    for (int i = 0; i < NW; i++) begin
      mem[SRC + 2*i] = ws[i][7:0];
      mem[SRC + 2*i + 1] = ws[i][15:8];
    end
    for (int i = 0; i < NW; i++) begin
      r = model(ws[i]);
      if (r[14]) es++;
      if (r[15]) ed++;
      exp_q.push_back({8'(DST + 2*i), r[7:0]});
      exp_q.push_back({8'(DST + 2*i + 1), r[15:8]});
    end
  endtask
  task automatic run_job(input bit poke, input int es, input int ed);
    int cyc;
    @(negedge clk); bus.req = 1'b1;
    @(posedge clk); #1 bus.req = 1'b0;
    chk("busy_after_accept", int'(bus.busy), 1);
    chk("done_after_accept", int'(bus.done), 0);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (poke) bus.req = (cyc == 10);
    end
    bus.req = 1'b0;
    chk("done_latency", cyc, 60);
    chk("busy_in_done", int'(bus.busy), 0);
    chk("n_single", int'(bus.n_single), es);
    chk("n_double", int'(bus.n_double), ed);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    logic [15:0] rw [NW];
    logic [15:0] v;
    int es, ed, b1, b2;
    reset = 1'b1;
    bus.req = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_we", int'(bus.mem_we), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_wdata", int'(bus.mem_wdata), 0);
    chk("rst_nsingle", int'(bus.n_single), 0);
    chk("rst_ndouble", int'(bus.n_double), 0);
    for (int i = 0; i < NW; i++) chk($sformatf("model_vec%0d", i), int'(model(tw[i])), int'(te[i]));
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      mem[SRC + 2*i] = tw[i][7:0];
      mem[SRC + 2*i + 1] = tw[i][15:8];
      exp_q.push_back({8'(DST + 2*i), te[i][7:0]});
      exp_q.push_back({8'(DST + 2*i + 1), te[i][15:8]});
    end
    run_job(1'b0, 7, 4);
    chk("src_untouched", int'(mem[SRC]), int'(tw[0][7:0]));
    for (int i = 0; i < NW; i++) begin
      v = encode(11'($urandom_range(0, 2047)));
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (i % 3 >= 1) v[b1] = ~v[b1];
      if (i % 3 == 2) v[b2] = ~v[b2];
      rw[i] = v;
    end
    load(rw, es, ed);
    chk("mix_singles", es, 5);
    chk("mix_doubles", ed, 5);
    run_job(1'b1, es, ed);
    for (int i = 0; i < NW; i++) rw[i] = encode(11'($urandom_range(0, 2047))) ^ (i % 2 == 1 ? 16'h0001 << (i % 16) : 16'h0000);
    load(rw, es, ed);
    @(negedge clk); bus.req = 1'b1;
    @(posedge clk); #1 bus.req = 1'b0;
    repeat (24) @(posedge clk);
    #2;
    chk("writes_before_reset", exp_q.size(), 2*(NW - 6));
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_we", int'(bus.mem_we), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_nsingle", int'(bus.n_single), 0);
    @(negedge clk);
    reset = 1'b0;
    load(rw, es, ed);
    run_job(1'b0, es, ed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
